// File: rtl/tile_sprite_mapper.sv
// Tile/sprite colour mapper: VGA scan position to 24-bit RGB via map RAM,
// sprite ROM bits and a writable 16-entry palette. Two-cycle fixed latency.
module tile_sprite_mapper #(
   parameter int NUM_TANKS    = 2,
   parameter int NUM_BULLETS  = 2,
   parameter int TILE_BITS    = 5,
   parameter int MAP_COLS     = 20,
   parameter int MAP_ROWS     = 15,
   parameter int BLINK_FRAMES = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     pix_valid,
   input  logic [9:0]               DrawX,
   input  logic [9:0]               DrawY,
   input  logic                     blank,
   input  logic                     frame_start,
   output logic [10:0]              map_addr,
   input  logic [2:0]               map_code,
   input  logic [6*NUM_TANKS-1:0]   tank_x,
   input  logic [6*NUM_TANKS-1:0]   tank_y,
   input  logic [6*NUM_BULLETS-1:0] bul_x,
   input  logic [6*NUM_BULLETS-1:0] bul_y,
   input  logic [NUM_BULLETS-1:0]   bul_en,
   input  logic [NUM_TANKS-1:0]     tank_pix,
   input  logic                     bul_pix,
   input  logic                     brk_pix,
   input  logic                     bush_pix,
   input  logic                     rck_pix,
   input  logic [NUM_TANKS-1:0]     tank_hit,
   input  logic                     pal_we,
   input  logic [3:0]               pal_addr,
   input  logic [23:0]              pal_data,
   output logic [7:0]               Red,
   output logic [7:0]               Green,
   output logic [7:0]               Blue,
   output logic                     rgb_valid
);

   localparam int CW = 10 - TILE_BITS;

   logic [CW-1:0] col, row;
   logic          in_range;

   logic          s1_valid, s1_blank, s1_inrng;
   logic [CW-1:0] s1_col, s1_row;

   logic [7:0]    blink [NUM_TANKS];
   logic [23:0]   pal [16];

   logic [2:0]    code;
   logic          bul_hit, tfound, tpix, tblink;
   logic [3:0]    tidx, pidx;

   function automatic logic [23:0] pal_default(input logic [3:0] i);
      case (i)
         4'd0:    return 24'h000000;
         4'd1:    return 24'h505050;
         4'd2:    return 24'h964B00;
         4'd3:    return 24'h421010;
         4'd4:    return 24'hFFD700;
         4'd5:    return 24'h90EE90;
         4'd6:    return 24'h228C22;
         4'd7:    return 24'hD3D3D3;
         4'd8:    return 24'hA8A8A8;
         4'd9:    return 24'hFFFFFF;
         4'd10:   return 24'hFF3131;
         4'd11:   return 24'h00FFFF;
         4'd12:   return 24'hFF00FF;
         4'd13:   return 24'hFFFF00;
         4'd14:   return 24'h3131FF;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   assign col      = DrawX[9:TILE_BITS];
   assign row      = DrawY[9:TILE_BITS];
   assign in_range = (int'(col) < MAP_COLS) && (int'(row) < MAP_ROWS);
   assign map_addr = in_range ? (11'(row) * 11'(MAP_COLS) + 11'(col)) : '0;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         s1_blank <= 1'b0;
         s1_inrng <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         s1_valid <= pix_valid;
         s1_blank <= blank;
         s1_inrng <= in_range;
         s1_col   <= col;
         s1_row   <= row;
      end
   end

   // Hit reload takes precedence over the frame decrement.
   always_ff @(posedge Clk) begin
      for (int unsigned i = 0; i < NUM_TANKS; i++) begin
         if (Reset)
            blink[i] <= '0;
         else if (tank_hit[i])
            blink[i] <= 8'(BLINK_FRAMES);
         else if (frame_start && blink[i] != '0)
            blink[i] <= blink[i] - 8'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < 16; i++)
            pal[i] <= pal_default(4'(i));
      end else if (pal_we) begin
         pal[pal_addr] <= pal_data;
      end
   end

   always_comb begin
      code    = s1_inrng ? map_code : 3'd0;
      bul_hit = 1'b0;
      tfound  = 1'b0;
      tpix    = 1'b0;
      tblink  = 1'b0;
      tidx    = '0;
      pidx    = '0;

      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
         if (bul_en[i] && 10'(bul_x[6*i +: 6]) == 10'(s1_col) &&
             10'(bul_y[6*i +: 6]) == 10'(s1_row))
            bul_hit = 1'b1;
      end

      // First match in ascending order gives lowest-index priority.
      for (int unsigned i = 0; i < NUM_TANKS; i++) begin
         if (!tfound && 10'(tank_x[6*i +: 6]) == 10'(s1_col) &&
             10'(tank_y[6*i +: 6]) == 10'(s1_row)) begin
            tfound = 1'b1;
            tidx   = 4'(i);
            tpix   = tank_pix[i];
            tblink = blink[i][0];
         end
      end

      if (s1_blank)
         pidx = 4'd0;
      else if (bul_hit && bul_pix)
         pidx = 4'd9;
      else begin
         case (code)
            3'd1:       pidx = 4'd1;
            3'd2:       pidx = brk_pix ? 4'd2 : 4'd3;
            3'd3, 3'd4: pidx = 4'd4;
            3'd5:       pidx = rck_pix ? 4'd7 : 4'd8;
            3'd6:       pidx = bush_pix ? 4'd5 : 4'd6;
            3'd0: begin
               if (tfound && tpix)
                  pidx = tblink ? 4'd15 : 4'd10 + tidx;
            end
            default:    pidx = 4'd0;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Red       <= '0;
         Green     <= '0;
         Blue      <= '0;
         rgb_valid <= 1'b0;
      end else begin
         rgb_valid <= s1_valid;
         if (s1_valid)
            {Red, Green, Blue} <= pal[pidx];
      end
   end

endmodule

// File: tb/tb_tile_sprite_mapper.sv
// Scoreboard bench for tile_sprite_mapper: directed pixels push expected colours,
// a forked monitor pops and checks colour and two-cycle latency on rgb_valid.
module tb_tile_sprite_mapper;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        pix_valid, blank, frame_start;
   logic [9:0]  DrawX, DrawY;
   logic [10:0] map_addr;
   logic [2:0]  map_code;
   logic [11:0] tank_x, tank_y, bul_x, bul_y;
   logic [1:0]  bul_en, tank_pix, tank_hit;
   logic        bul_pix, brk_pix, bush_pix, rck_pix;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [23:0] pal_data;
   logic [7:0]  Red, Green, Blue;
   logic        rgb_valid;

   logic [2:0]  map_mem [0:2047];

   typedef struct {
      logic [23:0] rgb;
      int unsigned due;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          nvec = 0;
   int          nmis = 0;
   logic        nopush = 1'b0;

   tile_sprite_mapper #(
      .NUM_TANKS(2), .NUM_BULLETS(2), .TILE_BITS(5),
      .MAP_COLS(20), .MAP_ROWS(15), .BLINK_FRAMES(3)
   ) dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .map_addr(map_addr), .map_code(map_code),
      .tank_x(tank_x), .tank_y(tank_y), .bul_x(bul_x), .bul_y(bul_y), .bul_en(bul_en),
      .tank_pix(tank_pix), .bul_pix(bul_pix), .brk_pix(brk_pix), .bush_pix(bush_pix),
      .rck_pix(rck_pix), .tank_hit(tank_hit), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_data(pal_data), .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;
   always @(posedge Clk) map_code <= map_mem[map_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pix(input int x, input int y, input logic b, input logic v,
                      input logic [23:0] e, input logic we);
      @(posedge Clk); #1;
      DrawX = 10'(x); DrawY = 10'(y); blank = b; pix_valid = v; pal_we = we;
      tank_hit = '0; frame_start = 1'b0;
      if (v && !nopush) q.push_back('{e, cyc + 2});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk); #1;
         pix_valid = 1'b0; pal_we = 1'b0; tank_hit = '0; frame_start = 1'b0;
      end
   endtask

   task automatic pix1(input int x, input int y, input logic [23:0] e);
      pix(x, y, 1'b0, 1'b1, e, 1'b0);
      idle(2);
   endtask

   task automatic ctl(input logic [1:0] h, input logic f);
      @(posedge Clk); #1;
      tank_hit = h; frame_start = f; pix_valid = 1'b0;
      idle(1);
   endtask

   task automatic do_reset();
      @(posedge Clk); #1;
      Reset = 1'b1; pix_valid = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; pix_valid = 1'b0; blank = 1'b0; frame_start = 1'b0;
      DrawX = '0; DrawY = '0; tank_x = '1; tank_y = '1; bul_x = '1; bul_y = '1;
      bul_en = '0; tank_pix = '0; bul_pix = 1'b0; brk_pix = 1'b0; bush_pix = 1'b0;
      rck_pix = 1'b0; tank_hit = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
      for (int i = 0; i < 2048; i++) map_mem[i] = 3'd0;
      map_mem[23]  = 3'd1;
      map_mem[106] = 3'd2;
      map_mem[107] = 3'd5;
      map_mem[108] = 3'd4;
      map_mem[109] = 3'd7;

      fork
         begin
            #100000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1);
         end
         forever begin
            @(negedge Clk);
            if (rgb_valid) begin
               if (q.size() == 0) begin
                  check("spurious_rgb_valid", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("rgb", 32'({Red, Green, Blue}), 32'(e.rgb));
                  check("latency", cyc, e.due);
               end
            end else if (q.size() != 0 && q[0].due < cyc) begin
               void'(q.pop_front());
               check("missing_rgb_valid", 32'd0, 32'd1);
            end
         end
      join_none

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
      check("reset_rgb", 32'({Red, Green, Blue}), 32'd0);
      @(posedge Clk); #1 Reset = 1'b0;
      idle(2);

      // Row y=40 across tiles 22/23/24 with periodic bubbles.
      for (int x = 94; x < 130; x++) begin
         pix(x, 40, 1'b0, (x % 5) != 0,
             (x >= 96 && x < 128) ? 24'h505050 : 24'h000000, 1'b0);
         #1 check("map_addr_row", 32'(map_addr), (x < 96) ? 32'd22 : (x < 128) ? 32'd23 : 32'd24);
      end
      idle(4);

      // Tanks, lowest-index priority, bush occlusion, bullets.
      tank_x = {6'd5, 6'd5}; tank_y = {6'd5, 6'd5}; tank_pix = 2'b11;
      pix1(163, 163, 24'hFF3131);
      tank_pix = 2'b10;
      pix1(170, 170, 24'h000000);
      tank_x = {6'd5, 6'd9};
      pix1(170, 170, 24'h00FFFF);
      tank_x = {6'd5, 6'd5}; tank_pix = 2'b11; map_mem[105] = 3'd6; bush_pix = 1'b0;
      pix1(163, 163, 24'h228C22);
      bush_pix = 1'b1;
      pix1(163, 163, 24'h90EE90);
      bul_x = {6'd5, 6'd63}; bul_y = {6'd5, 6'd63}; bul_en = 2'b10; bul_pix = 1'b1;
      pix1(163, 163, 24'hFFFFFF);
      bul_en = 2'b01;
      pix1(163, 163, 24'h90EE90);
      bul_en = 2'b00; map_mem[105] = 3'd0;
      brk_pix = 1'b1;
      pix1(200, 163, 24'h964B00);
      pix1(230, 163, 24'hA8A8A8);
      pix1(260, 163, 24'hFFD700);
      pix1(290, 163, 24'h000000);

      // Out-of-range tiles and blanking.
      map_mem[0] = 3'd1;
      pix(650, 40, 1'b0, 1'b1, 24'h000000, 1'b0);
      #1 check("map_addr_col20", 32'(map_addr), 32'd0);
      idle(2);
      pix(10, 480, 1'b0, 1'b1, 24'h000000, 1'b0);
      #1 check("map_addr_row15", 32'(map_addr), 32'd0);
      idle(2);
      pix1(10, 10, 24'h505050);
      pix(100, 40, 1'b1, 1'b1, 24'h000000, 1'b0);
      idle(2);

      // Palette write coincident with a lookup, then restored by reset.
      pal_addr = 4'd10; pal_data = 24'h123456;
      pix(163, 163, 1'b0, 1'b1, 24'hFF3131, 1'b0);
      pix(164, 163, 1'b0, 1'b1, 24'h123456, 1'b1);
      idle(3);
      do_reset();
      idle(1);
      pix1(163, 163, 24'hFF3131);

      // Blink with BLINK_FRAMES=3.
      ctl(2'b01, 1'b0); pix1(163, 163, 24'hFFFFFF);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFF3131);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFFFFFF);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFF3131);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFF3131);
      ctl(2'b01, 1'b0); pix1(163, 163, 24'hFFFFFF);
      ctl(2'b01, 1'b1); pix1(163, 163, 24'hFFFFFF);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFF3131);
      ctl(2'b00, 1'b1); pix1(163, 163, 24'hFFFFFF);

      // Reset mid-row with two pixels in flight.
      nopush = 1'b1;
      pix(163, 163, 1'b0, 1'b1, 24'h000000, 1'b0);
      pix(164, 163, 1'b0, 1'b1, 24'h000000, 1'b0);
      Reset = 1'b1;
      @(posedge Clk); #1 pix_valid = 1'b0;
      @(negedge Clk);
      check("midreset_rgb_valid", 32'(rgb_valid), 32'd0);
      check("midreset_rgb", 32'({Red, Green, Blue}), 32'd0);
      @(posedge Clk); #1 Reset = 1'b0;
      nopush = 1'b0;
      idle(6);
      pix1(163, 163, 24'hFF3131);

      idle(4);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/tile_sprite_mapper.md
Name: tile_sprite_mapper

Overview:
- Parametrised, pipelined successor to the tile/sprite colour mapper: converts the VGA scan position into 24-bit RGB.
- Fetches the tile code from a synchronous map RAM instead of a flat map array input.
- Supports N tanks and N bullets, a runtime-writable 16-entry palette, bush-over-tank occlusion and per-tank hit blinking.
- Sits between the VGA controller/sprite ROMs and the VGA DAC outputs.

Parameters:
NUM_TANKS, 2, tank channels (1..5)
NUM_BULLETS, 2, bullet channels (1..8)
TILE_BITS, 5, log2 tile edge in pixels (4..6)
MAP_COLS, 20, tiles per row
MAP_ROWS, 15, tile rows
BLINK_FRAMES, 8, frames a tank blinks after a hit (1..255)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
pix_valid  in  1  DrawX/DrawY/blank valid this cycle
DrawX  in  10  scan column
DrawY  in  10  scan row
blank  in  1  blanking interval
frame_start  in  1  one-cycle pulse per frame
map_addr  out  11  tile index to map RAM, combinational from DrawX/DrawY
map_code  in  3  map RAM data, valid one cycle after map_addr
tank_x, tank_y  in  6*NUM_TANKS  packed tile coordinates, tank i at [6i+5:6i]
bul_x, bul_y  in  6*NUM_BULLETS  packed bullet tile coordinates
bul_en  in  NUM_BULLETS  bullet i active
tank_pix  in  NUM_TANKS  tank sprite ROM bits
bul_pix, brk_pix, bush_pix, rck_pix  in  1 each  sprite ROM bits
tank_hit  in  NUM_TANKS  one-cycle hit pulses
pal_we  in  1  palette write strobe
pal_addr  in  4  palette index
pal_data  in  24  {R,G,B}
Red, Green, Blue  out  8 each  registered colour
rgb_valid  out  1  colour valid

Behaviour:
- Tile coordinates: col = DrawX >> TILE_BITS, row = DrawY >> TILE_BITS.
  - map_addr = row*MAP_COLS + col.
  - If col >= MAP_COLS or row >= MAP_ROWS: map_addr = 0, and the tile is forced to code 0 at stage 1.
- Pipeline, pixel presented at cycle N:
  - Stage 1 (N+1): registered position/blank/valid. map_code and all *_pix inputs are sampled for that pixel in this cycle.
  - Stage 2 (N+2): registered RGB and rgb_valid = stage-1 valid.
  - Fixed latency 2; one pixel per cycle; no stalls.
  - pix_valid=0 bubbles propagate; RGB holds its last value while rgb_valid=0.
- Colour priority at stage 1, highest first:
  1. blank → palette 0.
  2. Any bul_en[i] with matching tile and bul_pix=1 → palette 9.
  3. map_code 1 → palette 1.
  4. map_code 2 → palette 2 if brk_pix, else 3.
  5. map_code 3 or 4 → palette 4.
  6. map_code 5 → palette 7 if rck_pix, else 8.
  7. map_code 6 (bush) → palette 5 if bush_pix, else 6. Tanks under a bush are hidden.
  8. map_code 0 and a tank tile match → lowest-index matching tank i wins.
     - tank_pix[i]=0 → palette 0.
     - tank_pix[i]=1 and blinking phase on → palette 15.
     - Otherwise → palette 10+i.
  9. map_code 7 or no match → palette 0.
- Palette: 16×24 registers.
  - Reset defaults: 0:000000, 1:505050, 2:964B00, 3:421010, 4:FFD700, 5:90EE90, 6:228C22, 7:D3D3D3, 8:A8A8A8, 9:FFFFFF, 10:FF3131, 11:00FFFF, 12:FF00FF, 13:FFFF00, 14:3131FF, 15:FFFFFF.
  - A pal_we write at cycle W is visible to lookups from W+1 on. A stage-1 lookup in cycle W sees the old value.
- Blink, per tank: 8-bit counter.
  - tank_hit[i] loads BLINK_FRAMES, including retrigger while already blinking.
  - frame_start decrements a non-zero counter.
  - Hit and frame_start in the same cycle: the load wins.
  - Phase on when the counter is odd.
- Reset, including mid-frame:
  - RGB = 0, rgb_valid = 0, stage valids cleared, in-flight pixels discarded.
  - Blink counters = 0, palette restored to defaults.
  - First valid output is 2 cycles after the first pix_valid following reset release.

Test Plan:
- Reset, then stream a row at y=40 with map_code=1 at tile (3,1) → map_addr=23 for x=96..127; RGB=505050 exactly 2 cycles later; rgb_valid tracks pix_valid with 2-cycle delay.
- Tanks 0 and 1 both at tile (5,5), tank_pix=2'b11, code 0 → FF3131. Set code 6, bush_pix=0 → 228C22 (tank hidden). Bullet 1 at (5,5) with bul_pix=1 → FFFFFF over the bush.
- DrawX=650 (col 20) with map_code=1 returned → map_addr=0, colour treated as code 0, output 000000. blank=1 on any tile → 000000.
- pal_we to index 10 with 123456 in the same cycle tank 0 is looked up → that pixel is FF3131; the next pixel is 123456. Reset → FF3131 again.
- tank_hit[0] with BLINK_FRAMES=3, then frame pulses → tank fg FFFFFF, FF3131, FFFFFF, then FF3131 steady. A hit coincident with a frame_start reloads the counter to 3.
- Reset asserted mid-row with 2 pixels in flight → rgb_valid=0 and RGB=0 the next cycle; no stale pixel emerges after release.
